// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states and the iteration counter width helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the muldiv datapath: add-and-shift for multiply,
// restoring trial subtract for divide, on a {partial, operand} accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH:0]   nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH:0] sh;

  always_comb begin
    sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, b} : '0);
    sh    = {acc[2*WIDTH-1:0], 1'b0};
    trial = sh[2*WIDTH:WIDTH] - {1'b0, b};
    if (!is_div)
      nxt = {1'b0, sum, acc[WIDTH-1:1]};
    else if (trial[WIDTH])
      nxt = sh;
    else
      nxt = {trial, sh[WIDTH-1:1], 1'b1};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning HI/LO.
// Optional div0 flag output when MULDIV_DIV0_FLAG_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [1:0]       opr;
  logic [WIDTH-1:0] a_raw, bq;
  logic [2*WIDTH:0] acc, acc_n;
  logic             sa, sb;
  logic             sgn, is_div;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sgn    = 1'b0;
    is_div = 1'b0;
    unique case (opr)
      OP_MULT:  sgn = 1'b1;
      OP_MULTU: ;
      OP_DIV: begin
        sgn    = 1'b1;
        is_div = 1'b1;
      end
      OP_DIVU:  is_div = 1'b1;
    endcase
  end

  assign abs_a = (sgn && a_raw[WIDTH-1]) ? -a_raw : a_raw;
  assign abs_b = (sgn && bq[WIDTH-1]) ? -bq : bq;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc    (acc),
    .b      (bq),
    .nxt    (acc_n)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start && !flush) state_n = S_PREP;
      S_PREP: state_n = S_RUN;
      S_RUN:  if (cnt == CW'(WIDTH-1)) state_n = S_FIX;
      S_FIX:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush && state != S_IDLE) state_n = S_IDLE;
  end

  // Sign fix-up; divide by zero bypasses it and returns the raw dividend.
  always_comb begin
    prod = acc[2*WIDTH-1:0];
    hi_n = '0;
    lo_n = '0;
    if (!is_div) begin
      if (sa ^ sb) prod = -prod;
      {hi_n, lo_n} = prod;
    end else if (bq == '0) begin
      lo_n = '1;
      hi_n = a_raw;
    end else begin
      lo_n = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      hi_n = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      opr   <= OP_MULT;
      a_raw <= '0;
      bq    <= '0;
      acc   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0  <= 1'b0;
`endif
    end else begin
      busy <= (state_n != S_IDLE);
      done <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0 <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (start && !flush) begin
            opr   <= op;
            a_raw <= op_a;
            bq    <= op_b;
          end else if (!start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_PREP: begin
          sa  <= sgn && a_raw[WIDTH-1];
          sb  <= sgn && bq[WIDTH-1];
          acc <= {{(WIDTH+1){1'b0}}, abs_a};
          bq  <= abs_b;
          cnt <= '0;
        end
        S_RUN: begin
          acc <= acc_n;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (!flush) begin
            hi   <= hi_n;
            lo   <= lo_n;
            done <= 1'b1;
`ifdef MULDIV_DIV0_FLAG_EN
            div0 <= is_div && (bq == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
